// File: rtl/onehot_decoder_pkg.sv
// ============================================================================
// onehot_decoder_pkg : shared defaults and FSM state encoding for the decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

package onehot_decoder_pkg;

  localparam int DEF_N_OUT = 10;
  localparam int DEF_W_IN  = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/onehot_dec_core.sv
// ============================================================================
// onehot_dec_core : combinational binary code to one-hot word plus range flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module onehot_dec_core
  import onehot_decoder_pkg::*;
#(
  parameter int N_OUT = DEF_N_OUT,
  parameter int W_IN  = DEF_W_IN
) (
  input  logic [W_IN-1:0]  code,
  output logic [N_OUT-1:0] onehot,
  output logic             err
);

  // A code that matches no output line leaves the word all-zero and flags it.
  always_comb begin
    onehot = '0;
    err    = 1'b1;
    for (int i = 0; i < N_OUT; i++) begin
      if (code == W_IN'(i)) begin
        onehot[i] = 1'b1;
        err       = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/onehot_decoder.sv
// ============================================================================
// onehot_decoder : registered binary-to-one-hot decoder with 2-entry skid
//                  buffer and saturating out-of-range counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module onehot_decoder
  import onehot_decoder_pkg::*;
#(
  parameter int N_OUT = DEF_N_OUT,
  parameter int W_IN  = DEF_W_IN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iVALID,
  input  logic [W_IN-1:0]  iIN,
  output logic             oREADY,
  output logic             oVALID,
  output logic [N_OUT-1:0] oOUT,
  output logic             oERR,
  input  logic             iREADY,
  input  logic             iCNT_CLR,
  output logic [CNT_W-1:0] oERR_CNT
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_next;
  logic             ready_q;
  logic [N_OUT-1:0] out_q;
  logic             err_q;
  logic [N_OUT-1:0] skid_q;
  logic             skid_err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [N_OUT-1:0] dec_out;
  logic             dec_err;
  logic             accept;
  logic             pop;
  logic             load_out;
  logic             load_skid;
  logic             skid_to_out;
  logic             clear_out;

  assign accept = iVALID & ready_q;
  assign pop    = (state != ST_EMPTY) & iREADY;

  onehot_dec_core #(
    .N_OUT (N_OUT),
    .W_IN  (W_IN)
  ) u_core (
    .code   (iIN),
    .onehot (dec_out),
    .err    (dec_err)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= ST_EMPTY;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    clear_out   = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_next = ST_ONE;
          load_out   = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_out = 1'b1;
        end else if (pop) begin
          state_next = ST_EMPTY;
          clear_out  = 1'b1;
        end else if (accept) begin
          state_next = ST_FULL;
          load_skid  = 1'b1;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_next  = ST_ONE;
          skid_to_out = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // ready is registered from the next state so it is low throughout reset
  // and only rises on the first edge after release.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      ready_q    <= 1'b0;
      out_q      <= '0;
      err_q      <= 1'b0;
      skid_q     <= '0;
      skid_err_q <= 1'b0;
    end else begin
      ready_q <= (state_next != ST_FULL);
      if (load_out) begin
        out_q <= dec_out;
        err_q <= dec_err;
      end else if (skid_to_out) begin
        out_q <= skid_q;
        err_q <= skid_err_q;
      end else if (clear_out) begin
        out_q <= '0;
        err_q <= 1'b0;
      end
      if (load_skid) begin
        skid_q     <= dec_out;
        skid_err_q <= dec_err;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)                                          cnt_q <= '0;
    else if (iCNT_CLR)                                 cnt_q <= '0;
    else if (accept && dec_err && (cnt_q != CNT_MAX))  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign oREADY   = ready_q;
  assign oVALID   = (state != ST_EMPTY);
  assign oOUT     = out_q;
  assign oERR     = err_q;
  assign oERR_CNT = cnt_q;

endmodule

`default_nettype wire
